dds_demodulation: RTL and testbench

DDS_DEMODULATION -- requirements
Module: dds_demodulation

---
 rtl/dds_mod_pkg.sv | 34 +++
 rtl/dds_demodulation_if.sv | 27 ++
 rtl/dds_demod_mac.sv | 93 +++++++++
 rtl/dds_demodulation.sv | 128 ++++++++++++
 tb/tb_dds_demodulation.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_mod_pkg.sv
// Shared definitions for the DDS modulator/demodulator pair: mode codes,
// datapath widths and small helpers used by both ends of the link.
package dds_mod_pkg;

  localparam int SAMPLE_W = 12;
  localparam int LEN_W    = 10;
  localparam int ACC_W    = 34;
  localparam int THR_W    = 22;
  localparam int MOD_W    = 4;
  localparam int BITCNT_W = 16;

  typedef enum logic [MOD_W-1:0] {
    MOD_OOK  = 4'b0000,
    MOD_FSK  = 4'b0001,
    MOD_BPSK = 4'b0010,
    MOD_LFSR = 4'b0011
  } mod_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } demod_state_e;

  // Modes the demodulator can actually recover; everything else parks it.
  function automatic logic mode_supported(input logic [MOD_W-1:0] m);
    return (m == MOD_OOK) || (m == MOD_BPSK) || (m == MOD_LFSR);
  endfunction

  // A programmed length of zero behaves as a one-sample symbol.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/dds_demodulation_if.sv
// Sample stream, configuration and recovered-bit signals of the demodulator.
interface dds_demodulation_if;
  import dds_mod_pkg::*;

  logic signed [SAMPLE_W-1:0] in_sample;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] ref_carrier;
  logic [MOD_W-1:0]           modulation;
  logic [LEN_W-1:0]           symbol_len;
  logic [THR_W-1:0]           threshold;
  logic                       symbol_start;
  logic                       bit_out;
  logic                       bit_valid;
  logic [BITCNT_W-1:0]        bit_count;

  modport master (
    output in_sample, sample_valid, ref_carrier, modulation,
           symbol_len, threshold, symbol_start,
    input  bit_out, bit_valid, bit_count
  );

  modport slave (
    input  in_sample, sample_valid, ref_carrier, modulation,
           symbol_len, threshold, symbol_start,
    output bit_out, bit_valid, bit_count
  );
endinterface

// File: rtl/dds_demod_mac.sv
// Two-stage multiply/accumulate core: stage 1 forms the per-sample term for
// the active mode, stage 2 integrates it over a symbol and counts samples.
module dds_demod_mac
  import dds_mod_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int COEF_W = SAMPLE_W
)
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [COEF_W-1:0] ref_i,
  input  logic [MOD_W-1:0]         mode_i,
  input  logic                     vld_i,
  input  logic                     acc_en_i,
  input  logic                     clr_i,
  output logic                     vld_p1_o,
  output logic signed [ACC_W-1:0]  acc_sum_o,
  output logic [LEN_W:0]           cnt_inc_o
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] term_d;
  logic signed [PROD_W-1:0] term_p1_q;
  logic                     vld_p1_q;
  logic signed [ACC_W-1:0]  acc_p2_d;
  logic signed [ACC_W-1:0]  acc_p2_q;
  logic [LEN_W-1:0]         cnt_p2_d;
  logic [LEN_W-1:0]         cnt_p2_q;

  // Magnitude in the wider product width so that -2048 maps to +2048.
  function automatic logic signed [PROD_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
    logic signed [PROD_W-1:0] xe;
    xe = {{COEF_W{x[DATA_W-1]}}, x};
    return xe[PROD_W-1] ? -xe : xe;
  endfunction

  // ---- stage 0 -> 1: per-sample term ----
  // Select the term the current mode integrates.
  always_comb begin
    term_d = '0;
    case (mode_i)
      MOD_OOK:  term_d = magnitude(sample_i);
      MOD_BPSK: term_d = sample_i * ref_i;
      MOD_LFSR: term_d = (sample_i == $signed({1'b1, {(DATA_W-1){1'b0}}}))
                         ? {{(PROD_W-1){1'b0}}, 1'b1} : '0;
      default:  term_d = '0;
    endcase
  end

  // Stage 1 register; reloaded every cycle so stale terms never linger.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q  <= 1'b0;
      term_p1_q <= '0;
    end else begin
      vld_p1_q  <= vld_i;
      term_p1_q <= term_d;
    end
  end

  // ---- stage 1 -> 2: symbol integration ----
  assign acc_sum_o = acc_p2_q + $signed({{(ACC_W-PROD_W){term_p1_q[PROD_W-1]}}, term_p1_q});
  assign cnt_inc_o = {1'b0, cnt_p2_q} + (LEN_W+1)'(1);
  assign vld_p1_o  = vld_p1_q;

  // Clear wins over accumulate so a decision or realignment starts fresh.
  always_comb begin
    acc_p2_d = acc_p2_q;
    cnt_p2_d = cnt_p2_q;
    if (clr_i) begin
      acc_p2_d = '0;
      cnt_p2_d = '0;
    end else if (acc_en_i) begin
      acc_p2_d = acc_sum_o;
      cnt_p2_d = cnt_inc_o[LEN_W-1:0];
    end
  end

  // Stage 2 register: running sum and sample count of the current symbol.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_p2_q <= '0;
      cnt_p2_q <= '0;
    end else begin
      acc_p2_q <= acc_p2_d;
      cnt_p2_q <= cnt_p2_d;
    end
  end

endmodule

// File: rtl/dds_demodulation.sv
// DDS demodulator top: mode FSM, end-of-symbol decision and bit counter
// wrapped around the MAC core.
module dds_demodulation
  import dds_mod_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  dds_demodulation_if.slave bus
);

  demod_state_e             state_q;
  demod_state_e             state_d;
  logic                     run;
  logic [MOD_W-1:0]         mode_q;
  logic                     mode_chg;
  logic                     vld_in;
  logic                     vld_p1;
  logic                     acc_en;
  logic                     clr;
  logic                     decide;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [LEN_W:0]           cnt_inc;
  logic [LEN_W-1:0]         len_eff;
  logic                     bit_out_d;
  logic                     bit_out_q;
  logic                     bit_valid_d;
  logic                     bit_valid_q;
  logic [BITCNT_W-1:0]      bit_count_d;
  logic [BITCNT_W-1:0]      bit_count_q;

  // Slicer for a completed symbol; threshold and length are taken live.
  function automatic logic decide_bit(input logic [MOD_W-1:0]       mode,
                                      input logic signed [ACC_W-1:0] acc,
                                      input logic [LEN_W-1:0]        len,
                                      input logic [THR_W-1:0]        thr);
    logic signed [ACC_W-1:0] thr_s;
    logic signed [ACC_W-1:0] half_s;
    logic                    b;
    thr_s  = $signed({{(ACC_W-THR_W){1'b0}}, thr});
    half_s = $signed({{(ACC_W-LEN_W){1'b0}}, len >> 1});
    case (mode)
      MOD_BPSK: b = acc[ACC_W-1];
      MOD_LFSR: b = (acc > half_s);
      default:  b = (acc >= thr_s);
    endcase
    return b;
  endfunction

  assign len_eff  = eff_len(bus.symbol_len);
  assign mode_chg = (bus.modulation != mode_q);
  assign vld_in   = bus.sample_valid && mode_supported(bus.modulation);

  // FSM state and previous-mode registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= bus.modulation;
    end
  end

  // Supported modes run, FSK and reserved codes park the block.
  always_comb begin
    state_d = mode_supported(bus.modulation) ? ST_RUN : ST_IDLE;
  end

  // FSM output: integration is only enabled while running.
  always_comb begin
    run = (state_q == ST_RUN);
  end

  dds_demod_mac #(
    .DATA_W (SAMPLE_W),
    .COEF_W (SAMPLE_W)
  ) u_mac (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_i  (bus.in_sample),
    .ref_i     (bus.ref_carrier),
    .mode_i    (bus.modulation),
    .vld_i     (vld_in),
    .acc_en_i  (acc_en),
    .clr_i     (clr),
    .vld_p1_o  (vld_p1),
    .acc_sum_o (acc_sum),
    .cnt_inc_o (cnt_inc)
  );

  // ---- stage 2: decision, alongside the accumulate ----
  // A mode change throws away whatever symbol was in flight, including one
  // that would have completed on this very edge.
  always_comb begin
    acc_en = run && vld_p1;
    decide = acc_en && !mode_chg && (cnt_inc >= {1'b0, len_eff});
    clr    = !run || decide || bus.symbol_start || mode_chg;
  end

  // Output next-state: strobe on decision, hold the bit otherwise.
  always_comb begin
    bit_valid_d = decide;
    bit_out_d   = bit_out_q;
    bit_count_d = bit_count_q;
    if (decide) begin
      bit_out_d   = decide_bit(bus.modulation, acc_sum, len_eff, bus.threshold);
      bit_count_d = bit_count_q + BITCNT_W'(1);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_count_q <= '0;
    end else begin
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_dds_demodulation.sv
// Bench for dds_demodulation: directed scenarios plus random traffic, all
// checked every cycle against a symbol-level reference model.
module tb_dds_demodulation;
  import dds_mod_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dds_demodulation_if bus();

  dds_demodulation dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: samples of the symbol being collected, the
  // sample waiting one cycle before it lands, and expected outputs.
  longint      m_sum;
  int          m_n;
  bit          m_pend;
  longint      m_pend_term;
  logic [3:0]  m_prev_mode;
  bit          m_exp_valid;
  bit          m_exp_bit;
  logic [15:0] m_count;
  bit          got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic got_at(input int i);
    if (i < got.size()) return got[i];
    return 1'bx;
  endfunction

  function automatic longint sample_term(input logic [3:0] m, input logic signed [11:0] x,
                                         input logic signed [11:0] r);
    int xs;
    int rs;
    xs = x;
    rs = r;
    case (m)
      4'd0:    return (xs < 0) ? -xs : xs;
      4'd2:    return longint'(xs) * longint'(rs);
      4'd3:    return (xs == -2048) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_sum = 0; m_n = 0; m_pend = 0; m_pend_term = 0;
    m_prev_mode = 4'd0; m_exp_valid = 0; m_exp_bit = 0; m_count = 16'd0;
  endtask

  // Called on each rising edge with the inputs present during that cycle.
  task automatic model_edge();
    logic [3:0] m;
    bit sup;
    bit changed;
    int L;
    m = bus.modulation;
    sup = (m == 4'd0) || (m == 4'd2) || (m == 4'd3);
    changed = (m != m_prev_mode);
    L = (bus.symbol_len == 0) ? 1 : int'(bus.symbol_len);
    m_exp_valid = 0;
    if (m_pend && !changed) begin
      m_sum += m_pend_term;
      m_n++;
      if (m_n >= L) begin
        m_exp_valid = 1;
        if (m == 4'd2)      m_exp_bit = (m_sum < 0);
        else if (m == 4'd3) m_exp_bit = (m_sum > longint'(L / 2));
        else                m_exp_bit = (m_sum >= longint'(bus.threshold));
        m_count++;
        m_sum = 0;
        m_n = 0;
      end
    end
    if (bus.symbol_start || changed || !sup) begin
      m_sum = 0;
      m_n = 0;
    end
    m_pend = bus.sample_valid && sup;
    m_pend_term = sample_term(m, bus.in_sample, bus.ref_carrier);
    m_prev_mode = m;
  endtask

  task automatic step(input bit v, input logic [11:0] x, input logic [11:0] r, input bit s);
    bus.sample_valid = v;
    bus.in_sample    = x;
    bus.ref_carrier  = r;
    bus.symbol_start = s;
    @(posedge clk);
    model_edge();
    #1;
    chk("bit_valid", bus.bit_valid, m_exp_valid);
    chk("bit_out", bus.bit_out, m_exp_bit);
    chk("bit_count", bus.bit_count, m_count);
    if (bus.bit_valid === 1'b1) got.push_back(bus.bit_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000, 12'h000, 1'b0);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_bit_out", bus.bit_out, 0);
    chk("rst_bit_valid", bus.bit_valid, 0);
    chk("rst_bit_count", bus.bit_count, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", bus.bit_valid, 0);
    chk("rst_hold_count", bus.bit_count, 0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [11:0] x;
    int r;
    reset_n          = 1'b0;
    bus.in_sample    = '0;
    bus.sample_valid = 1'b0;
    bus.ref_carrier  = '0;
    bus.modulation   = 4'd2;
    bus.symbol_len   = 10'd8;
    bus.threshold    = '0;
    bus.symbol_start = 1'b0;
    model_reset();
    do_reset();

    // BPSK: in-phase symbol then inverted symbol.
    got.delete();
    idle(1);
    for (int i = 0; i < 8; i++) step(1'b1, 12'h400, 12'h400, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 12'hC00, 12'h400, 1'b0);
    idle(2);
    chk("bpsk_nbits", got.size(), 2);
    chk("bpsk_bit0", got_at(0), 0);
    chk("bpsk_bit1", got_at(1), 1);
    chk("bpsk_count", bus.bit_count, 2);

    // OOK: sum exactly at threshold, then just below.
    got.delete();
    bus.modulation = 4'd0; bus.symbol_len = 10'd4; bus.threshold = 22'd4000;
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b1, 12'd1000, 12'h000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 12'd999, 12'h000, 1'b0);
    idle(2);
    chk("ook_nbits", got.size(), 2);
    chk("ook_bit0", got_at(0), 1);
    chk("ook_bit1", got_at(1), 0);

    // LFSR: 3 marks of 5 beats half, 2 marks does not.
    got.delete();
    bus.modulation = 4'd3; bus.symbol_len = 10'd5;
    idle(1);
    for (int i = 0; i < 5; i++) step(1'b1, (i < 3) ? 12'h800 : 12'h000, 12'h000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, (i < 2) ? 12'h800 : 12'h000, 12'h000, 1'b0);
    idle(2);
    chk("lfsr_nbits", got.size(), 2);
    chk("lfsr_bit0", got_at(0), 1);
    chk("lfsr_bit1", got_at(1), 0);

    // symbol_start on a decision cycle: decision kept, new symbol begins.
    got.delete();
    bus.modulation = 4'd2; bus.symbol_len = 10'd4;
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b1, 12'h400, 12'h400, 1'b0);
    step(1'b1, 12'hC00, 12'h400, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 12'hC00, 12'h400, 1'b0);
    idle(2);
    chk("start_dec_nbits", got.size(), 2);
    chk("start_dec_bit0", got_at(0), 0);
    chk("start_dec_bit1", got_at(1), 1);

    // Length shrunk below the running count.
    got.delete();
    bus.symbol_len = 10'd8;
    for (int i = 0; i < 5; i++) step(1'b1, 12'h400, 12'h400, 1'b0);
    idle(1);
    bus.symbol_len = 10'd3;
    step(1'b1, 12'hC00, 12'h400, 1'b0);
    idle(2);
    chk("shrink_nbits", got.size(), 1);
    chk("shrink_bit", got_at(0), 0);

    // Gapped samples with realignment after 3 of 8.
    got.delete();
    bus.symbol_len = 10'd8;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 12'h400, 12'h400, 1'b0);
      step(1'b0, 12'h000, 12'h000, i == 2);
    end
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 12'h400, 12'h400, 1'b0);
      step(1'b0, 12'h000, 12'h000, 1'b0);
    end
    chk("gap_early", got.size(), 0);
    step(1'b1, 12'h400, 12'h400, 1'b0);
    idle(2);
    chk("gap_nbits", got.size(), 1);

    // Mode change to FSK mid-symbol and back.
    got.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 12'h400, 12'h400, 1'b0);
    bus.modulation = 4'd1;
    for (int i = 0; i < 6; i++) step(1'b1, 12'h400, 12'h400, 1'b0);
    chk("fsk_nbits", got.size(), 0);
    bus.modulation = 4'd2;
    for (int i = 0; i < 7; i++) step(1'b1, 12'h400, 12'h400, 1'b0);
    idle(2);
    chk("mchg_early", got.size(), 0);
    step(1'b1, 12'h400, 12'h400, 1'b0);
    idle(2);
    chk("mchg_nbits", got.size(), 1);

    // Reset in the middle of a symbol.
    got.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 12'hC00, 12'h400, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 12'hC00, 12'h400, 1'b0);
    idle(2);
    chk("rst_early", got.size(), 0);
    step(1'b1, 12'hC00, 12'h400, 1'b0);
    idle(2);
    chk("rst_nbits", got.size(), 1);
    chk("rst_count", bus.bit_count, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        r = $urandom_range(0, 11);
        if (r < 3)       bus.modulation = 4'd0;
        else if (r < 6)  bus.modulation = 4'd2;
        else if (r < 9)  bus.modulation = 4'd3;
        else if (r == 9) bus.modulation = 4'd1;
        else             bus.modulation = 4'($urandom_range(4, 15));
      end
      if ($urandom_range(0, 49) == 0) bus.symbol_len = 10'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) bus.threshold = 22'($urandom_range(0, 20000));
      x = ($urandom_range(0, 3) == 0) ? 12'h800 : 12'($urandom);
      step($urandom_range(0, 9) < 7, x, 12'($urandom), $urandom_range(0, 39) == 0);
    end

    // bit_count wrap with one-sample symbols.
    do_reset();
    got.delete();
    bus.modulation = 4'd0; bus.symbol_len = 10'd0; bus.threshold = 22'd0;
    for (int i = 0; i < 65535; i++) step(1'b1, 12'd5, 12'h000, 1'b0);
    idle(1);
    chk("wrap_pre", bus.bit_count, 16'hFFFF);
    step(1'b1, 12'd5, 12'h000, 1'b0);
    idle(1);
    chk("wrap", bus.bit_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
